// File: rtl/dual_port_ram_ctrl.sv
// Shared 32-bit word RAM with an independent instruction read port and data
// read/write port, each with a fixed number of wait states before its response.

module dual_port_ram_ctrl_port #(
  parameter int WAIT_N = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        acc,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_N);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] pend_data;
  logic        pend_err;

  assign acc = req & ready & en;

  // The response word is captured at acceptance and parked until RESP so rdata
  // only changes when rvalid pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b1;
      rvalid    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      pend_data <= '0;
      pend_err  <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      if (acc) begin
        if (WAIT_N == 0) begin
          state  <= RESP;
          ready  <= 1'b1;
          rvalid <= 1'b1;
          rdata  <= rsp_data;
          err    <= rsp_err;
        end else begin
          state     <= WAIT;
          cnt       <= WAIT_CNT;
          ready     <= 1'b0;
          pend_data <= rsp_data;
          pend_err  <= rsp_err;
        end
      end else begin
        case (state)
          WAIT: begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              state  <= RESP;
              ready  <= 1'b1;
              rvalid <= 1'b1;
              rdata  <= pend_data;
              err    <= pend_err;
            end
          end
          default: begin
            state <= IDLE;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

module dual_port_ram_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int MEM_WORDS  = 32768,
  parameter int I_WAIT     = 0,
  parameter int D_WAIT     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  output logic        inst_err,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err
);
  localparam logic [ADDR_WIDTH:0] WORD_LIM = (ADDR_WIDTH+1)'(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic                  rst_q;
  logic [ADDR_WIDTH-1:0] i_idx, d_idx;
  logic                  i_bad, d_bad, i_acc, d_acc, d_wr;
  logic [31:0]           d_old, d_merged, d_rsp, i_rsp;
  logic                  unused_addr_hi;

  // Deassertion is seen one edge late, so the earliest acceptance is the second edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_q <= 1'b0;
    else      rst_q <= 1'b1;
  end

  assign i_idx = inst_addr[ADDR_WIDTH+1:2];
  assign d_idx = data_addr[ADDR_WIDTH+1:2];
  assign i_bad = (inst_addr[1:0] != 2'b00) || ({1'b0, i_idx} >= WORD_LIM);
  assign d_bad = (data_addr[1:0] != 2'b00) || ({1'b0, d_idx} >= WORD_LIM);
  assign unused_addr_hi = ^{inst_addr[31:ADDR_WIDTH+2], data_addr[31:ADDR_WIDTH+2]};

  always_comb begin
    d_old    = d_bad ? '0 : mem[d_idx];
    d_merged = d_old;
    for (int b = 0; b < 4; b++)
      if (data_wen[b]) d_merged[8*b +: 8] = data_wdata[8*b +: 8];
    d_wr  = d_acc && (data_wen != 4'h0) && !d_bad;
    d_rsp = d_bad ? '0 : ((data_wen != 4'h0) ? d_merged : d_old);
    // A same-edge data write to the fetched word is forwarded (write-first).
    if (i_bad)                      i_rsp = '0;
    else if (d_wr && d_idx == i_idx) i_rsp = d_merged;
    else                            i_rsp = mem[i_idx];
  end

  always_ff @(posedge clk) begin
    if (d_wr) mem[d_idx] <= d_merged;
  end

  dual_port_ram_ctrl_port #(.WAIT_N(I_WAIT)) u_inst (
    .clk(clk), .rst(rst), .en(rst_q), .req(inst_req),
    .rsp_data(i_rsp), .rsp_err(i_bad), .acc(i_acc),
    .ready(inst_ready), .rvalid(inst_rvalid), .rdata(inst_rdata), .err(inst_err)
  );

  dual_port_ram_ctrl_port #(.WAIT_N(D_WAIT)) u_data (
    .clk(clk), .rst(rst), .en(rst_q), .req(data_req),
    .rsp_data(d_rsp), .rsp_err(d_bad), .acc(d_acc),
    .ready(data_ready), .rvalid(data_rvalid), .rdata(data_rdata), .err(data_err)
  );
endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Two controllers with different wait counts share one stimulus stream; each is
// compared every cycle against a countdown/array model of its port behaviour.

module tb_dual_port_ram_ctrl;
  localparam int AW = 10;
  localparam int MW = 768;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wen;
  logic [1:0]  i_ready, i_rvalid, i_err, d_ready, d_rvalid, d_err;
  logic [31:0] i_rdata [2];
  logic [31:0] d_rdata [2];

  int nchk = 0;
  int nfail = 0;

  // model: per dut k, port p (0 inst, 1 data)
  logic [31:0] mm [2][MW];
  int          rem  [2][2];
  logic [31:0] pdat [2][2];
  logic [31:0] rdat [2][2];
  bit          perr [2][2];
  bit          sync_ok [2];

  always #5 clk = ~clk;

  dual_port_ram_ctrl #(.ADDR_WIDTH(AW), .MEM_WORDS(MW), .I_WAIT(3), .D_WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(i_ready[0]),
    .inst_rvalid(i_rvalid[0]), .inst_rdata(i_rdata[0]), .inst_err(i_err[0]),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(d_ready[0]), .data_rvalid(d_rvalid[0]), .data_rdata(d_rdata[0]), .data_err(d_err[0])
  );

  dual_port_ram_ctrl #(.ADDR_WIDTH(AW), .MEM_WORDS(MW), .I_WAIT(0), .D_WAIT(5)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(i_ready[1]),
    .inst_rvalid(i_rvalid[1]), .inst_rdata(i_rdata[1]), .inst_err(i_err[1]),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(d_ready[1]), .data_rvalid(d_rvalid[1]), .data_rdata(d_rdata[1]), .data_err(d_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wt(input int k, input int p);
    if (k == 0) return (p == 0) ? 3 : 0;
    return (p == 0) ? 0 : 5;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << AW));
  endfunction

  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (widx(a) >= MW);
  endfunction

  task automatic model_reset(input int k);
    for (int p = 0; p < 2; p++) begin
      rem[k][p] = 0; pdat[k][p] = '0; rdat[k][p] = '0; perr[k][p] = 1'b0;
    end
    sync_ok[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    bit ia, da;
    logic [31:0] old, nw, res;
    int ix;
    if (!rst) begin
      model_reset(k);
      return;
    end
    ia = sync_ok[k] && inst_req && rem[k][0] <= 1;
    da = sync_ok[k] && data_req && rem[k][1] <= 1;
    for (int p = 0; p < 2; p++) if (rem[k][p] > 0) rem[k][p]--;
    if (da) begin
      res = '0;
      if (!bad(data_addr)) begin
        ix  = widx(data_addr);
        old = mm[k][ix];
        nw  = old;
        for (int b = 0; b < 4; b++) if (data_wen[b]) nw[8*b +: 8] = data_wdata[8*b +: 8];
        if (data_wen != 4'h0) begin mm[k][ix] = nw; res = nw; end
        else res = old;
      end
      rem[k][1] = wt(k, 1) + 1; pdat[k][1] = res; perr[k][1] = bad(data_addr);
    end
    if (ia) begin
      res = '0;
      if (!bad(inst_addr)) res = mm[k][widx(inst_addr)];
      rem[k][0] = wt(k, 0) + 1; pdat[k][0] = res; perr[k][0] = bad(inst_addr);
    end
    for (int p = 0; p < 2; p++) if (rem[k][p] == 1) rdat[k][p] = pdat[k][p];
    sync_ok[k] = 1'b1;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d_i_ready", k),  32'(i_ready[k]),  32'(rem[k][0] <= 1));
      chk($sformatf("u%0d_i_rvalid", k), 32'(i_rvalid[k]), 32'(rem[k][0] == 1));
      chk($sformatf("u%0d_i_err", k),    32'(i_err[k]),    32'(rem[k][0] == 1 && perr[k][0]));
      chk($sformatf("u%0d_i_rdata", k),  i_rdata[k],       rdat[k][0]);
      chk($sformatf("u%0d_d_ready", k),  32'(d_ready[k]),  32'(rem[k][1] <= 1));
      chk($sformatf("u%0d_d_rvalid", k), 32'(d_rvalid[k]), 32'(rem[k][1] == 1));
      chk($sformatf("u%0d_d_err", k),    32'(d_err[k]),    32'(rem[k][1] == 1 && perr[k][1]));
      chk($sformatf("u%0d_d_rdata", k),  d_rdata[k],       rdat[k][1]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input logic [3:0] w,
                     input logic [31:0] da, input logic [31:0] wd);
    inst_req = ir; inst_addr = ia; data_req = dr; data_wen = w; data_addr = da; data_wdata = wd;
  endtask

  task automatic idle(input int n);
    drv(0, '0, 0, '0, '0, '0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_reset(input int hold);
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check_all();
    for (int i = 0; i < hold; i++) cycle();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] raddr();
    int r;
    logic [31:0] w;
    r = $urandom_range(0, 15);
    w = 32'($urandom_range(0, 15));
    case (r)
      0:       return (w << 2) | 32'($urandom_range(1, 3));
      1:       return 32'($urandom_range(MW, (1 << AW) - 1)) << 2;
      2:       return (w << 2) | (32'($urandom) << (AW + 2));
      3:       return 32'h100;
      4:       return 32'h200;
      default: return w << 2;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    drv(0, '0, 0, '0, '0, '0);
    model_reset(0);
    model_reset(1);
    #1 rst = 1'b0;
    #1 check_all();
    cycle();
    cycle();
    rst = 1'b1;

    // write 0x100; first edge after release must not accept
    drv(0, '0, 1, 4'hF, 32'h100, 32'hDEADBEEF);
    cycle();
    chk("sync_no_acc", 32'(d_rvalid[0]), 32'd0);
    cycle();
    chk("wr_vld", 32'(d_rvalid[0]), 32'd1);
    chk("wr_data", d_rdata[0], 32'hDEADBEEF);
    idle(8);

    // read back, then byte merge back-to-back
    drv(0, '0, 1, 4'h0, 32'h100, '0);
    cycle();
    chk("rd_data", d_rdata[0], 32'hDEADBEEF);
    chk("rd_err", 32'(d_err[0]), 32'd0);
    drv(0, '0, 1, 4'h1, 32'h100, 32'h000000AA);
    cycle();
    chk("merge_vld", 32'(d_rvalid[0]), 32'd1);
    chk("merge_data", d_rdata[0], 32'hDEADBEAA);
    idle(8);

    // three instruction wait states on u_dut0
    drv(1, 32'h100, 0, '0, '0, '0);
    cycle();
    drv(0, '0, 0, '0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      chk("iw_ready_low", 32'(i_ready[0]), 32'd0);
      cycle();
    end
    chk("iw_vld", 32'(i_rvalid[0]), 32'd1);
    chk("iw_ready_back", 32'(i_ready[0]), 32'd1);
    chk("iw_data", i_rdata[0], 32'hDEADBEAA);
    cycle();
    chk("iw_vld_pulse", 32'(i_rvalid[0]), 32'd0);
    idle(8);

    // same-edge write and fetch of one word
    drv(1, 32'h200, 1, 4'hF, 32'h200, 32'h12345678);
    cycle();
    drv(0, '0, 0, '0, '0, '0);
    chk("coll_u1_inst", i_rdata[1], 32'h12345678);
    for (int c = 0; c < 3; c++) cycle();
    chk("coll_u0_vld", 32'(i_rvalid[0]), 32'd1);
    chk("coll_u0_inst", i_rdata[0], 32'h12345678);
    idle(8);

    // errors: misaligned, out of range, then good accesses including alias
    drv(0, '0, 1, 4'h0, 32'h102, '0);
    cycle();
    chk("mis_err", 32'(d_err[0]), 32'd1);
    chk("mis_data", d_rdata[0], 32'd0);
    drv(0, '0, 1, 4'hF, 32'(MW) << 2, 32'hFFFFFFFF);
    cycle();
    chk("oor_err", 32'(d_err[0]), 32'd1);
    chk("oor_data", d_rdata[0], 32'd0);
    drv(1, 32'h102, 1, 4'hF, 32'h102, 32'h0);
    cycle();
    chk("miswr_err", 32'(d_err[0]), 32'd1);
    drv(0, '0, 1, 4'h0, 32'h100, '0);
    cycle();
    chk("after_err_err", 32'(d_err[0]), 32'd0);
    chk("after_err_data", d_rdata[0], 32'hDEADBEAA);
    drv(0, '0, 1, 4'h0, 32'h100 | (32'd1 << (AW + 2)), '0);
    cycle();
    chk("alias_data", d_rdata[0], 32'hDEADBEAA);
    drv(0, '0, 0, '0, '0, '0);
    cycle();
    chk("imis_err", 32'(i_err[0]), 32'd1);
    chk("imis_data", i_rdata[0], 32'd0);
    idle(8);

    // reset two cycles into a 5-wait data write on u_dut1
    drv(0, '0, 1, 4'hF, 32'h104, 32'hCAFEF00D);
    cycle();
    drv(0, '0, 0, '0, '0, '0);
    cycle();
    cycle();
    pulse_reset(2);
    chk("rst_u1_ready", 32'(d_ready[1]), 32'd1);
    drv(0, '0, 1, 4'h0, 32'h104, '0);
    cycle();
    cycle();
    drv(0, '0, 0, '0, '0, '0);
    chk("rst_keep_u0", d_rdata[0], 32'hCAFEF00D);
    for (int c = 0; c < 5; c++) cycle();
    chk("rst_keep_u1_vld", 32'(d_rvalid[1]), 32'd1);
    chk("rst_keep_u1", d_rdata[1], 32'hCAFEF00D);
    idle(8);

    // fill the random working set; held long enough for the 5-wait port
    for (int w = 0; w < 16; w++) begin
      drv(0, '0, 1, 4'hF, 32'(w) << 2, $urandom);
      for (int c = 0; c < 6; c++) cycle();
    end
    idle(8);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) pulse_reset(2);
      drv($urandom_range(0, 9) < 7, raddr(),
          $urandom_range(0, 9) < 7, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
          raddr(), $urandom);
      cycle();
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
